// File: rtl/alu_cdb_if.sv
// rtl/alu_cdb_if.sv - result-capture and broadcast signals between ALU station, CDB stage and ROB
interface alu_cdb_if #(
  parameter int RS_NUM_WIDTH = 3,
  parameter int TAG_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32
);
  logic                    flush;
  logic                    in_valid;
  logic [RS_NUM_WIDTH-1:0] in_rsnum;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    rob_ready;
  logic                    out_finish;
  logic [RS_NUM_WIDTH-1:0] out_rsnum;
  logic [TAG_WIDTH-1:0]    out_tag;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [RS_NUM_WIDTH:0]   count;

  modport master (
    output flush, in_valid, in_rsnum, in_tag, in_data, rob_ready,
    input  out_finish, out_rsnum, out_tag, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_rsnum, in_tag, in_data, rob_ready,
    output out_finish, out_rsnum, out_tag, out_data, count
  );
endinterface

// File: rtl/alu_cdb.sv
// rtl/alu_cdb.sv - ALU common data bus stage: dedups station re-issues, queues results, broadcasts one per cycle
module alu_cdb #(
  parameter int                    RS_SIZE      = 8,
  parameter int                    RS_NUM_WIDTH = 3,
  parameter int                    TAG_WIDTH    = 4,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [TAG_WIDTH-1:0]  TAG_FREE     = '0
) (
  input  logic       clk,
  input  logic       rst,
  alu_cdb_if.slave   bus
);
  localparam logic [RS_NUM_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [RS_NUM_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [RS_NUM_WIDTH:0]   CNT_FULL = (RS_NUM_WIDTH+1)'(RS_SIZE);

  logic [RS_NUM_WIDTH-1:0] q_rsnum [RS_SIZE];
  logic [TAG_WIDTH-1:0]    q_tag   [RS_SIZE];
  logic [DATA_WIDTH-1:0]   q_data  [RS_SIZE];
  logic [RS_NUM_WIDTH-1:0] head, tail;
  logic [RS_NUM_WIDTH:0]   cnt;
  logic [RS_SIZE-1:0]      pending, pending_nxt;
  logic                    ret_valid;
  logic [RS_NUM_WIDTH-1:0] ret_rsnum;

  logic                    finish_r;
  logic [RS_NUM_WIDTH-1:0] rsnum_r;
  logic [TAG_WIDTH-1:0]    tag_r;
  logic [DATA_WIDTH-1:0]   data_r;

  logic accept, pop, bypass, push;

  always_comb begin
    accept = bus.in_valid && (bus.in_tag != TAG_FREE) && !pending[bus.in_rsnum] && !bus.flush;
    pop    = bus.rob_ready && (cnt != '0);
    bypass = bus.rob_ready && (cnt == '0) && accept;
    push   = accept && !bypass;
    // Release the slot broadcast last cycle before marking the new arrival,
    // so the station's one trailing re-issue is still filtered.
    pending_nxt = pending;
    if (ret_valid) pending_nxt[ret_rsnum] = 1'b0;
    if (accept)    pending_nxt[bus.in_rsnum] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rsnum[tail] <= bus.in_rsnum;
      q_tag[tail]   <= bus.in_tag;
      q_data[tail]  <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      pending   <= '0;
      ret_valid <= 1'b0;
      ret_rsnum <= '0;
      finish_r  <= 1'b0;
      rsnum_r   <= '0;
      tag_r     <= TAG_FREE;
      data_r    <= '0;
    end else begin
      assert (!(push && cnt == CNT_FULL));
      pending <= pending_nxt;
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
      ret_valid <= pop || bypass;
      ret_rsnum <= pop ? q_rsnum[head] : bus.in_rsnum;
      if (pop) begin
        finish_r <= 1'b1;
        rsnum_r  <= q_rsnum[head];
        tag_r    <= q_tag[head];
        data_r   <= q_data[head];
      end else if (bypass) begin
        finish_r <= 1'b1;
        rsnum_r  <= bus.in_rsnum;
        tag_r    <= bus.in_tag;
        data_r   <= bus.in_data;
      end else begin
        finish_r <= 1'b0;
        rsnum_r  <= '0;
        tag_r    <= TAG_FREE;
        data_r   <= '0;
      end
    end
  end

  assign bus.out_finish = finish_r;
  assign bus.out_rsnum  = rsnum_r;
  assign bus.out_tag    = tag_r;
  assign bus.out_data   = data_r;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_alu_cdb.sv
// tb/tb_alu_cdb.sv - self-checking bench for alu_cdb with a queue-based reference model
module tb_alu_cdb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cdb_if #(.RS_NUM_WIDTH(3), .TAG_WIDTH(4), .DATA_WIDTH(32)) bus ();

  alu_cdb #(
    .RS_SIZE(8), .RS_NUM_WIDTH(3), .TAG_WIDTH(4), .DATA_WIDTH(32), .TAG_FREE(4'd0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int unsigned rsnum;
    int unsigned tag;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  bit          prev_valid;
  int unsigned prev_slot;
  bit          exp_finish;
  int unsigned exp_rsnum, exp_tag;
  logic [31:0] exp_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q.delete();
    prev_valid = 0;
    prev_slot  = 0;
    exp_finish = 0;
    exp_rsnum  = 0;
    exp_tag    = 0;
    exp_data   = '0;
  endfunction

  // A slot is busy while it sits in the queue or was broadcast one posedge ago.
  function automatic void model_step(input bit v, input int unsigned r, input int unsigned t,
                                     input logic [31:0] d, input bit ready, input bit fl, input bit rs);
    bit     in_q, acc, bc;
    entry_t e, n;
    if (rs || fl) begin
      model_clear();
      return;
    end
    in_q = 0;
    foreach (q[i]) if (q[i].rsnum == r) in_q = 1;
    acc = v && (t != 0) && !in_q && !(prev_valid && prev_slot == r);
    n.rsnum = r; n.tag = t; n.data = d;
    bc = 0;
    e  = n;
    if (ready && q.size() > 0) begin
      e  = q.pop_front();
      bc = 1;
      if (acc) q.push_back(n);
    end else if (ready && acc) begin
      bc = 1;
    end else if (acc) begin
      q.push_back(n);
    end
    exp_finish = bc;
    exp_rsnum  = bc ? e.rsnum : 0;
    exp_tag    = bc ? e.tag : 0;
    exp_data   = bc ? e.data : '0;
    prev_valid = bc;
    prev_slot  = e.rsnum;
  endfunction

  task automatic compare_all();
    chk("out_finish", {31'd0, bus.out_finish}, {31'd0, exp_finish});
    chk("out_rsnum",  {29'd0, bus.out_rsnum},  exp_rsnum);
    chk("out_tag",    {28'd0, bus.out_tag},    exp_tag);
    chk("out_data",   bus.out_data,            exp_data);
    chk("count",      {28'd0, bus.count},      q.size());
  endtask

  task automatic step(input bit v, input int unsigned r, input int unsigned t, input logic [31:0] d,
                      input bit ready, input bit fl, input bit rs);
    @(negedge clk);
    rst           = rs;
    bus.flush     = fl;
    bus.in_valid  = v;
    bus.in_rsnum  = 3'(r);
    bus.in_tag    = 4'(t);
    bus.in_data   = d;
    bus.rob_ready = ready;
    model_step(v, r, t, d, ready, fl, rs);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_rsnum = 0; bus.in_tag = 0;
    bus.in_data = 0; bus.rob_ready = 0;
    model_clear();

    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("reset_finish", {31'd0, bus.out_finish}, 32'd0);
    chk("reset_tag",    {28'd0, bus.out_tag},    32'd0);
    chk("reset_count",  {28'd0, bus.count},      32'd0);

    // Single result, then its re-issue and a fresh result for the same slot
    step(1, 2, 5, 32'h7, 1, 0, 0);
    chk("t1_finish", {31'd0, bus.out_finish}, 32'd1);
    chk("t1_rsnum",  {29'd0, bus.out_rsnum},  32'd2);
    chk("t1_tag",    {28'd0, bus.out_tag},    32'd5);
    chk("t1_data",   bus.out_data,            32'd7);
    step(1, 2, 5, 32'h7, 1, 0, 0);
    chk("t2_dup_finish", {31'd0, bus.out_finish}, 32'd0);
    chk("t2_dup_tag",    {28'd0, bus.out_tag},    32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 2, 6, 32'h9, 1, 0, 0);
    chk("t2_new_tag",  {28'd0, bus.out_tag}, 32'd6);
    chk("t2_new_data", bus.out_data,         32'd9);

    // Stall ordering with re-issues
    step(1, 1, 3, 32'h10, 0, 0, 0);
    step(1, 4, 7, 32'h20, 0, 0, 0);
    step(1, 0, 2, 32'h30, 0, 0, 0);
    step(1, 1, 3, 32'h10, 0, 0, 0);
    step(1, 4, 7, 32'h20, 0, 0, 0);
    step(1, 0, 2, 32'h30, 0, 0, 0);
    chk("t3_count",  {28'd0, bus.count},      32'd3);
    chk("t3_finish", {31'd0, bus.out_finish}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_tag0", {28'd0, bus.out_tag}, 32'd3);
    chk("t3_cnt0", {28'd0, bus.count},   32'd2);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_tag1", {28'd0, bus.out_tag}, 32'd7);
    chk("t3_cnt1", {28'd0, bus.count},   32'd1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_tag2", {28'd0, bus.out_tag}, 32'd2);
    chk("t3_cnt2", {28'd0, bus.count},   32'd0);

    // Free tag is never accepted
    step(1, 3, 0, 32'h55, 1, 0, 0);
    chk("t4_finish", {31'd0, bus.out_finish}, 32'd0);
    chk("t4_count",  {28'd0, bus.count},      32'd0);

    // Flush with a colliding arrival
    step(1, 1, 4, 32'h40, 0, 0, 0);
    step(1, 3, 5, 32'h50, 0, 0, 0);
    chk("t5_count_pre", {28'd0, bus.count}, 32'd2);
    step(1, 5, 6, 32'h60, 0, 1, 0);
    chk("t5_count", {28'd0, bus.count}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t5_nopulse", {31'd0, bus.out_finish}, 32'd0);
    step(1, 1, 8, 32'hAB, 1, 0, 0);
    chk("t5_tag",   {28'd0, bus.out_tag},   32'd8);
    chk("t5_rsnum", {29'd0, bus.out_rsnum}, 32'd1);

    // Reset while broadcasting
    step(1, 2, 9,  32'h90, 0, 0, 0);
    step(1, 3, 10, 32'hA0, 0, 0, 0);
    step(1, 4, 11, 32'hB0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_tag", {28'd0, bus.out_tag}, 32'd9);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t6_rst_finish", {31'd0, bus.out_finish}, 32'd0);
    chk("t6_rst_count",  {28'd0, bus.count},      32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_post_finish", {31'd0, bus.out_finish}, 32'd0);
    step(1, 3, 12, 32'h12, 1, 0, 0);
    chk("t6_new_tag", {28'd0, bus.out_tag}, 32'd12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 15), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cdb.md
Name: alu_cdb

Overview:
- Common data bus stage on the result side of the ALU reservation station.
- Captures the registered result pulses the ALU station issues, and drops the duplicate re-issues the station produces until its slot is freed.
- Queues accepted results in issue order and broadcasts one per cycle as a single-cycle finish pulse.
- The pulse goes to the ALU station (slot release and operand wake-up) and to the ROB.

Parameters:
- RS_SIZE, 8: number of ALU reservation-station slots; also the queue depth.
- RS_NUM_WIDTH, 3: width of a slot index, equal to log2(RS_SIZE).
- TAG_WIDTH, 4: ROB tag width.
- DATA_WIDTH, 32: result data width.
- TAG_FREE, 0: tag value meaning "no producer".

Ports:
- clk  input  1  clock
- rst  input  1  reset
- flush  input  1  misprediction flush from the ROB
- in_valid  input  1  ALU result valid (ALU aluSignal)
- in_rsnum  input  RS_NUM_WIDTH  issuing slot
- in_tag  input  TAG_WIDTH  destination ROB tag
- in_data  input  DATA_WIDTH  result value
- rob_ready  input  1  ROB can take a broadcast this cycle
- out_finish  output  1  broadcast pulse (drives ALU aluFinish)
- out_rsnum  output  RS_NUM_WIDTH  slot to release
- out_tag  output  TAG_WIDTH  broadcast tag
- out_data  output  DATA_WIDTH  broadcast data
- count  output  RS_NUM_WIDTH+1  queued entries, not counting the one on the outputs

Behaviour:
- Reset and clock: rst is synchronous and active-high; clk is the clock. All state updates on the posedge of clk.
- Reset values:
  - out_finish=0, out_rsnum=0, out_tag=TAG_FREE, out_data=0.
  - count=0; queue empty; pending bitmap=0; retiring register cleared.
- Accept rule: at a posedge, a result is accepted iff in_valid=1, in_tag!=TAG_FREE, pending[in_rsnum]=0 and flush=0. Otherwise it is silently dropped.
- On accept: set pending[in_rsnum] and push {rsnum, tag, data}.
- Broadcast rule: at each posedge with rob_ready=1, the oldest available entry is loaded into the out_* registers and out_finish=1 for exactly that cycle.
  - The oldest available entry is the queue head or, if the queue is empty, the incoming accepted result.
  - Bypass latency: in_valid sampled at posedge N appears on the outputs in the cycle after posedge N.
  - Queued entries leave in strict acceptance order; at most one broadcast per cycle.
- Idle outputs: when no broadcast occurs (rob_ready=0 or nothing available), out_finish=0, out_rsnum=0, out_tag=TAG_FREE, out_data=0. A stalled entry is not held on the outputs.
- Pending release:
  - When slot r is broadcast at posedge N, r is recorded as retiring.
  - pending[r] clears at posedge N+1, so the station's single re-issue arriving at posedge N+1 is dropped.
  - A result for slot r arriving at posedge N+2 or later is accepted as new.
- Stall: while rob_ready=0, the queue holds and repeated re-issues of pending slots are dropped. count reflects the queue.
- Simultaneous accept and broadcast in the same cycle: push and pop both happen; count is unchanged (bypass: count stays 0).
- Capacity: one entry per slot at most, so the queue can never overflow. Push while full is an assertion failure.
- Flush: synchronous, at the posedge with flush=1.
  - Clears the queue, the pending bitmap and retiring, and sets count=0.
  - Outputs go to idle values; in_valid in that cycle is dropped.
  - flush has priority below rst.
- Reset mid-operation: everything returns to reset values at that posedge. No broadcast is produced in the following cycle.

Test Plan:
1. Single result: rob_ready=1; in_valid for one cycle with rsnum=2, tag=5, data=0x0000_0007 at posedge N -> after N, out_finish=1, out_rsnum=2, out_tag=5, out_data=7; after N+1, out_finish=0, out_tag=0; count=0 throughout.
2. Duplicate drop: same slot 2/tag 5 re-issued at N+1 -> no second pulse. Fresh slot 2, tag 6, data 9 at N+3 -> a pulse with tag 6, data 9.
3. Stall ordering: rob_ready=0; accept slot 1 (tag 3, data 0x10), slot 4 (tag 7, data 0x20), slot 0 (tag 2, data 0x30) over three cycles, each re-issued every cycle -> count=3, no pulses. Raise rob_ready -> pulses in order tag 3, 7, 2 on consecutive cycles; count 2, 1, 0.
4. Tag filter: in_valid=1 with in_tag=TAG_FREE (0) -> no accept, no pulse, count stays 0.
5. Flush: with 2 queued and rob_ready=0, assert flush together with a new in_valid (slot 5) -> count=0, outputs idle. Raise rob_ready -> no pulse. A result for slot 1 (previously pending) is then accepted and broadcast.
6. Reset mid-stream: 3 entries queued, broadcasting; assert rst for one cycle -> all outputs at reset values next cycle, count=0, pending cleared. A result for a previously queued slot is accepted afterwards.
